param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, storage depth in words (power of 2, >=4).
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, equal to log2(DEPTH).
REQ-004 SHALL have parameter AFULL_THRESH, default 14, almost_full level in words (1..DEPTH-1).
REQ-005 SHALL have parameter AEMPTY_THRESH, default 2, almost_empty level in words (1..DEPTH-1).
REQ-006 SHALL have parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-007 SHALL have port clk  input  1  sole clock; all logic on rising edge; one clock.
REQ-008 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-009 SHALL have port wr_ena  input  1  write request.
REQ-010 SHALL have port wr_data  input  WIDTH  write data.
REQ-011 SHALL have port rd_ena  input  1  read request (FWFT=1: acknowledge of presented word).
REQ-012 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-013 SHALL have port rd_data  output  WIDTH  read data.
REQ-014 SHALL have port rd_valid  output  1  rd_data holds a valid word.
REQ-015 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 SHALL have port count  output  ADDR_WIDTH+1  words held, 0..DEPTH.
REQ-017 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 SHALL store data in an internal DEPTH x WIDTH register array; no external RAM instance.
REQ-019 SHALL keep wr_ptr and rd_ptr ADDR_WIDTH+1 bits wide; low bits address, MSB toggles on wrap from DEPTH-1 to 0.
REQ-020 SHALL accept a write when wr_ena=1 and (full=0 or a read is accepted the same cycle).
REQ-021 SHALL accept a read when rd_ena=1 and empty=0; never when empty=1, even with a simultaneous write.
REQ-022 SHALL update count as registered value: +1 write only, -1 read only, unchanged both or neither.
REQ-023 SHALL drive full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_THRESH), almost_empty = (count<=AEMPTY_THRESH), all decoded from registered count.
REQ-024 SHALL (FWFT=0) present the word at rd_ptr on rd_data one cycle after an accepted read, with rd_valid high for exactly that cycle; rd_data holds its value otherwise.
REQ-025 SHALL (FWFT=1) present the head word on rd_data with rd_valid=1 whenever count>0; an accepted read advances rd_data to the next word on the following cycle.
REQ-026 SHALL (FWFT=1) make a word written into an empty FIFO visible on rd_data with rd_valid=1 on the cycle after the write edge.
REQ-027 SHALL set overflow when wr_ena=1 and the write is rejected; set underflow when rd_ena=1 and empty=1.
REQ-028 SHALL clear overflow and underflow on clr_err=1; a same-cycle set condition SHALL win over clear.
REQ-029 SHALL leave pointers, count and array contents unchanged by rejected requests.

Reset
REQ-030 SHALL on rst=1, immediately and independent of clk, force wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-031 SHALL therefore show empty=1, almost_empty=1, full=0, almost_full=0 during and after reset.
REQ-032 SHALL discard all stored words on reset asserted mid-operation; array contents need not be cleared.
REQ-033 SHALL accept no request on the first rising edge at which rst is high.

Verification
REQ-034 SHALL pass: FWFT=0, write 0x01..0x10 (16 words) -> full=1, count=16, almost_full from 14th write; 17th write -> overflow=1, count=16.
REQ-035 SHALL pass: FWFT=0, read 16 words -> rd_data 0x01..0x10 in order, each one cycle after request; then read -> underflow=1, empty=1.
REQ-036 SHALL pass: full FIFO, simultaneous wr_ena/rd_ena with 0xAA -> count stays 16, no overflow, 0xAA read last after 40 total writes (wrap twice).
REQ-037 SHALL pass: FWFT=1, single write 0x5A to empty -> next cycle rd_valid=1, rd_data=0x5A, empty=0; rd_ena -> next cycle empty=1, rd_valid=0.
REQ-038 SHALL pass: 5 words stored, rst pulsed between clock edges -> count=0, empty=1, flags clear immediately; subsequent write 0x33 reads back 0x33.
REQ-039 SHALL pass: overflow set, clr_err=1 with no error -> overflow=0 next cycle; clr_err=1 with rejected write same cycle -> overflow stays 1.

Source files
------------

// File: rtl/param_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_fifo
// Brief    : Parameterised synchronous FIFO with register-array storage,
//            registered or first-word-fall-through read port, status flags,
//            occupancy count and sticky overflow/underflow error flags.
// Revision : 1.0 - initial release
// ============================================================================
module param_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_ena,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_ena,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    // Count-width constants so every compare and increment is width-matched.
    localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] c_ONE    = (ADDR_WIDTH+1)'(1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                w_unused_ptr_msb;

    // Status flags are decoded purely from the registered occupancy count.
    assign w_full       = (r_count == c_DEPTH);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AFULL);
    assign almost_empty = (r_count <= c_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A read never fires on an empty FIFO; a write into a full FIFO is only
    // allowed when a read frees a slot in the same cycle.
    assign w_rd_acc  = rd_ena & ~w_empty;
    assign w_wr_acc  = wr_ena & (~w_full | w_rd_acc);

    assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

    // Pointer MSBs track wrap parity; occupancy comes from r_count instead.
    assign w_unused_ptr_msb = r_wr_ptr[ADDR_WIDTH] ^ r_rd_ptr[ADDR_WIDTH];

    // Storage array: written on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    // Pointer advance on accepted requests; natural wrap toggles the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
        end
    end

    // Occupancy count: up on write only, down on read only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_ena && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_ena && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally whenever the FIFO holds data,
            // so a write into an empty FIFO appears right after its edge.
            assign rd_valid = ~w_empty;
            assign rd_data  = w_empty ? '0 : r_mem[w_rd_addr];
        end else begin : g_std
            logic [WIDTH-1:0] r_rd_data;
            logic             r_rd_valid;

            // Registered read: data lands one cycle after the accepted read
            // and is held until the next accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[w_rd_addr];
                    end
                end
            end

            assign rd_valid = r_rd_valid;
            assign rd_data  = r_rd_data;
        end
    endgenerate

endmodule
`default_nettype wire
